// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and types for the two-requester data memory arbiter.
// Optional build macro: DATA_MEM_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
package data_mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } req_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Request/response and memory-side bundle for data_mem_arbiter.
// The slave modport is the arbiter; the master modport is requesters plus memory.
interface data_mem_arb_if;
  import data_mem_arb_pkg::*;

  logic              ReqValid0, ReqValid1;
  logic              ReqReady0, ReqReady1;
  logic              ReqWrite0, ReqWrite1;
  logic [ADDR_W-1:0] ReqAddr0,  ReqAddr1;
  logic [LEN_W-1:0]  ReqLen0,   ReqLen1;
  logic [DATA_W-1:0] WData0,    WData1;
  logic              BeatAck0,  BeatAck1;
  logic              RspValid0, RspValid1;
  logic [DATA_W-1:0] RspData0,  RspData1;
  logic              MemWriteEn;
  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemDataIn;
  logic [DATA_W-1:0] MemDataOut;

  modport slave (
    input  ReqValid0, ReqValid1, ReqWrite0, ReqWrite1, ReqAddr0, ReqAddr1,
           ReqLen0, ReqLen1, WData0, WData1, MemDataOut,
    output ReqReady0, ReqReady1, BeatAck0, BeatAck1, RspValid0, RspValid1,
           RspData0, RspData1, MemWriteEn, MemAddress, MemDataIn
  );

  modport master (
    output ReqValid0, ReqValid1, ReqWrite0, ReqWrite1, ReqAddr0, ReqAddr1,
           ReqLen0, ReqLen1, WData0, WData1, MemDataOut,
    input  ReqReady0, ReqReady1, BeatAck0, BeatAck1, RspValid0, RspValid1,
           RspData0, RspData1, MemWriteEn, MemAddress, MemDataIn
  );

endinterface

// File: rtl/data_mem_arbiter_arb2_pick.sv
// Two-way winner select with a round-robin pointer that flips away from each grantee.
// With DATA_MEM_ARB_FIXED_PRIO_EN defined, requester 0 always wins and the pointer is removed.
module arb2_pick
  import data_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_grant,
  output req_id_t    o_winner,
  output logic       o_any
);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  wire w_unused = ^{clk, rst_n, i_grant};

  always_comb begin
    o_any    = |i_valid;
    o_winner = i_valid[0] ? req_id_t'(1'b0) : req_id_t'(1'b1);
  end
`else
  req_id_t r_prio;

  // NOTE: every output of a combinational block gets a default up front so no path can infer a latch.
  always_comb begin
    o_any    = |i_valid;
    o_winner = i_valid[0] ? req_id_t'(1'b0) : req_id_t'(1'b1);
    if (&i_valid) o_winner = r_prio;
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_prio <= '0;
    else if (i_grant) r_prio <= ~o_winner;
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port 256x8 data memory between two burst requesters.
// Build option DATA_MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  data_mem_arb_if.slave bus
);

  state_t            r_state;
  req_id_t           r_owner;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_rsp_valid0, r_rsp_valid1;
  logic [DATA_W-1:0] r_rsp_data0, r_rsp_data1;

  req_id_t w_winner;
  logic    w_any;
  logic    w_grant;
  logic    w_beat_wr;
  req_t    w_req;

  arb2_pick u_pick (
    .clk      (Clk),
    .rst_n    (Reset),
    .i_valid  ({bus.ReqValid1, bus.ReqValid0}),
    .i_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Reset gates the grant so ReqReady stays low while reset is held.
  assign w_grant   = (r_state == IDLE) && w_any && Reset;
  assign w_beat_wr = (r_state == BURST) && r_write;

  always_comb begin
    w_req = '{write: bus.ReqWrite0, addr: bus.ReqAddr0, len: bus.ReqLen0};
    if (w_winner == req_id_t'(1'b1))
      w_req = '{write: bus.ReqWrite1, addr: bus.ReqAddr1, len: bus.ReqLen1};
  end

  assign bus.ReqReady0  = w_grant && (w_winner == req_id_t'(1'b0));
  assign bus.ReqReady1  = w_grant && (w_winner == req_id_t'(1'b1));
  assign bus.MemWriteEn = w_beat_wr;
  assign bus.MemAddress = r_addr;
  assign bus.MemDataIn  = !w_beat_wr                   ? '0 :
                          (r_owner == req_id_t'(1'b1)) ? bus.WData1 : bus.WData0;
  assign bus.BeatAck0   = w_beat_wr && (r_owner == req_id_t'(1'b0));
  assign bus.BeatAck1   = w_beat_wr && (r_owner == req_id_t'(1'b1));
  assign bus.RspValid0  = r_rsp_valid0;
  assign bus.RspValid1  = r_rsp_valid1;
  assign bus.RspData0   = r_rsp_data0;
  assign bus.RspData1   = r_rsp_data1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_rsp_data0  <= '0;
      r_rsp_data1  <= '0;
    end else begin
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner     <= w_winner;
            r_write     <= w_req.write;
            r_addr      <= w_req.addr;
            r_remaining <= w_req.len;
            r_state     <= BURST;
          end
        end
        BURST: begin
          if (!r_write) begin
            if (r_owner == req_id_t'(1'b1)) begin
              r_rsp_data1  <= bus.MemDataOut;
              r_rsp_valid1 <= 1'b1;
            end else begin
              r_rsp_data0  <= bus.MemDataOut;
              r_rsp_valid0 <= 1'b1;
            end
          end
          // Address wraps naturally at 2**ADDR_W.
          r_addr      <= r_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == '0) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural 256x8 memory.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  logic Clk;
  logic Reset;
  logic tb_mem_load;
  logic [DATA_W-1:0] mem [256];
  int checks;
  int errors;

  data_mem_arb_if bus_if ();

  data_mem_arbiter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (tb_mem_load) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k) ^ 8'h5A;
    end else if (bus_if.MemWriteEn) begin
      mem[bus_if.MemAddress] <= bus_if.MemDataIn;
    end
  end

  assign bus_if.MemDataOut = mem[bus_if.MemAddress];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_addr;
    logic       exp_win;
    checks      = 0;
    errors      = 0;
    tb_mem_load = 1'b1;
    Reset       = 1'b0;
    bus_if.ReqValid0 = 1'b1; bus_if.ReqValid1 = 1'b1;
    bus_if.ReqWrite0 = 1'b0; bus_if.ReqWrite1 = 1'b0;
    bus_if.ReqAddr0  = '0;   bus_if.ReqAddr1  = '0;
    bus_if.ReqLen0   = '0;   bus_if.ReqLen1   = '0;
    bus_if.WData0    = '0;   bus_if.WData1    = '0;

    // Reset held with both requests pending
    repeat (3) tick();
    tb_mem_load = 1'b0;
    #1;
    check("rst_ready0",   bus_if.ReqReady0,  0);
    check("rst_ready1",   bus_if.ReqReady1,  0);
    check("rst_we",       bus_if.MemWriteEn, 0);
    check("rst_addr",     bus_if.MemAddress, 0);
    check("rst_din",      bus_if.MemDataIn,  0);
    check("rst_ack0",     bus_if.BeatAck0,   0);
    check("rst_ack1",     bus_if.BeatAck1,   0);
    check("rst_rspv0",    bus_if.RspValid0,  0);
    check("rst_rspv1",    bus_if.RspValid1,  0);
    check("rst_rspd0",    bus_if.RspData0,   0);
    check("rst_rspd1",    bus_if.RspData1,   0);

    // Release: requester 0 wins first, then Len=0 contention
    Reset = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
      exp_win = 1'b0;
`else
      exp_win = g[0];
`endif
      check($sformatf("cont_ready0_g%0d", g), bus_if.ReqReady0, {31'd0, ~exp_win});
      check($sformatf("cont_ready1_g%0d", g), bus_if.ReqReady1, {31'd0, exp_win});
      if (g == 1) begin
        check("cont_rspv0", bus_if.RspValid0, 1);
        check("cont_rspd0", bus_if.RspData0,  32'h5A);
      end
      tick();
      if (g == 3) begin
        bus_if.ReqValid0 = 1'b0;
        bus_if.ReqValid1 = 1'b0;
      end
      #1;
      check($sformatf("cont_burst_ready_g%0d", g), {bus_if.ReqReady1, bus_if.ReqReady0}, 0);
      tick();
      #1;
    end
    tick();

    // Write burst from requester 0: 0x10..0x13 <= 0xA0..0xA3
    bus_if.ReqWrite0 = 1'b1;
    bus_if.ReqAddr0  = 8'h10;
    bus_if.ReqLen0   = 4'd3;
    bus_if.WData0    = 8'hA0;
    bus_if.ReqValid0 = 1'b1;
    #1;
    check("wr_ready0", bus_if.ReqReady0, 1);
    check("wr_idle_we", bus_if.MemWriteEn, 0);
    tick();
    bus_if.ReqValid0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      bus_if.WData0 = 8'(8'hA0 + i);
      #1;
      check($sformatf("wr_we_b%0d", i),   bus_if.MemWriteEn, 1);
      check($sformatf("wr_addr_b%0d", i), bus_if.MemAddress, 32'(8'h10 + i));
      check($sformatf("wr_din_b%0d", i),  bus_if.MemDataIn,  32'(8'hA0 + i));
      check($sformatf("wr_ack0_b%0d", i), bus_if.BeatAck0,   1);
      check($sformatf("wr_ack1_b%0d", i), bus_if.BeatAck1,   0);
    end
    tick();
    #1;
    check("wr_done_we",   bus_if.MemWriteEn, 0);
    check("wr_done_ack0", bus_if.BeatAck0,   0);
    check("wr_done_addr", bus_if.MemAddress, 32'h14);
    for (int i = 0; i < 4; i++)
      check($sformatf("wr_mem_%0d", i), mem[8'h10 + i], 32'(8'hA0 + i));

    // Read burst from requester 1 of the same region
    bus_if.ReqWrite1 = 1'b0;
    bus_if.ReqAddr1  = 8'h10;
    bus_if.ReqLen1   = 4'd3;
    bus_if.ReqValid1 = 1'b1;
    #1;
    check("rd_ready1", bus_if.ReqReady1, 1);
    check("rd_ready0", bus_if.ReqReady0, 0);
    tick();
    bus_if.ReqValid1 = 1'b0;
    #1;
    check("rd_b0_we",    bus_if.MemWriteEn, 0);
    check("rd_b0_addr",  bus_if.MemAddress, 32'h10);
    check("rd_b0_rspv1", bus_if.RspValid1,  0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check($sformatf("rd_rspv1_%0d", i), bus_if.RspValid1, 1);
      check($sformatf("rd_rspd1_%0d", i), bus_if.RspData1,  32'(8'hA0 + i));
      check($sformatf("rd_rspv0_%0d", i), bus_if.RspValid0, 0);
    end
    tick();
    #1;
    check("rd_end_rspv1", bus_if.RspValid1, 0);

    // Address wrap: requester 0 writes 0xFE..0x01
    bus_if.ReqWrite0 = 1'b1;
    bus_if.ReqAddr0  = 8'hFE;
    bus_if.ReqLen0   = 4'd3;
    bus_if.WData0    = 8'h30;
    bus_if.ReqValid0 = 1'b1;
    #1;
    check("wrap_ready0", bus_if.ReqReady0, 1);
    tick();
    bus_if.ReqValid0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      bus_if.WData0 = 8'(8'h30 + i);
      exp_addr      = 8'(8'hFE + i);
      #1;
      check($sformatf("wrap_addr_b%0d", i), bus_if.MemAddress, {24'd0, exp_addr});
      check($sformatf("wrap_we_b%0d", i),   bus_if.MemWriteEn, 1);
    end
    tick();
    #1;
    check("wrap_mem_ff", mem[8'hFF], 32'h31);
    check("wrap_mem_00", mem[8'h00], 32'h32);
    check("wrap_mem_01", mem[8'h01], 32'h33);

    // Reset during the 2nd beat of a Len=7 write from requester 1
    bus_if.ReqWrite1 = 1'b1;
    bus_if.ReqAddr1  = 8'h40;
    bus_if.ReqLen1   = 4'd7;
    bus_if.WData1    = 8'hC0;
    bus_if.ReqValid1 = 1'b1;
    #1;
    check("abort_ready1", bus_if.ReqReady1, 1);
    tick();
    bus_if.ReqValid1 = 1'b0;
    #1;
    check("abort_b0_addr", bus_if.MemAddress, 32'h40);
    check("abort_b0_we",   bus_if.MemWriteEn, 1);
    tick();
    bus_if.WData1 = 8'hC1;
    #1;
    check("abort_b1_addr", bus_if.MemAddress, 32'h41);
    Reset = 1'b0;
    #1;
    check("abort_we",   bus_if.MemWriteEn, 0);
    check("abort_ack1", bus_if.BeatAck1,   0);
    check("abort_addr", bus_if.MemAddress, 0);
    repeat (3) tick();
    Reset = 1'b1;
    #1;
    check("abort_mem_40", mem[8'h40], 32'hC0);
    for (int k = 2; k < 8; k++)
      check($sformatf("abort_mem_%0h", 8'h40 + k), mem[8'h40 + k], 32'(8'(8'h40 + k) ^ 8'h5A));
    check("abort_idle_we",  bus_if.MemWriteEn, 0);
    check("abort_idle_rdy", {bus_if.ReqReady1, bus_if.ReqReady0}, 0);

    // Back in IDLE with the pointer reset: requester 0 wins the tie
    bus_if.ReqWrite0 = 1'b0; bus_if.ReqWrite1 = 1'b0;
    bus_if.ReqLen0   = '0;   bus_if.ReqLen1   = '0;
    bus_if.ReqValid0 = 1'b1; bus_if.ReqValid1 = 1'b1;
    #1;
    check("post_rst_ready0", bus_if.ReqReady0, 1);
    check("post_rst_ready1", bus_if.ReqReady1, 0);
    tick();
    bus_if.ReqValid0 = 1'b0; bus_if.ReqValid1 = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port 256x8 data memory between two requesters: requester 0 is the processor core's load/store unit, requester 1 is the loader/debug port. Each request is a burst of 1..16 consecutive read or write beats. The block arbitrates round-robin, sequences addresses, and drives the memory's write enable, address and write data. Read data is registered back to the owning requester.

Parameters:
ADDR_W, 8, memory address width (256-deep memory)
DATA_W, 8, data width
LEN_W, 4, burst length field width; a burst is Len+1 beats (max 16)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
ReqValid0/ReqValid1  in  1  request pending from requester 0/1
ReqReady0/ReqReady1  out  1  request accepted this cycle (combinational)
ReqWrite0/ReqWrite1  in  1  1 = write burst, 0 = read burst
ReqAddr0/ReqAddr1  in  ADDR_W  burst start address
ReqLen0/ReqLen1  in  LEN_W  beats minus one
WData0/WData1  in  DATA_W  write data for the current beat
BeatAck0/BeatAck1  out  1  current write beat consumed; requester advances WData next cycle
RspValid0/RspValid1  out  1  read data valid
RspData0/RspData1  out  DATA_W  registered read data
MemWriteEn  out  1  to memory write enable
MemAddress  out  ADDR_W  to memory address
MemDataIn  out  DATA_W  to memory write data
MemDataOut  in  DATA_W  from memory; combinational read of MemAddress

Behaviour:
- States: IDLE, BURST. Reset (Reset=0, async) -> IDLE. All outputs 0, owner=0, rr pointer favours requester 0, addr_reg=0, remaining=0, RspData*=0.
- IDLE:
  - If any ReqValid is high, pick a winner and assert its ReqReady in the same cycle. Only one ReqReady is ever high.
  - On the next edge, latch owner, write flag, addr_reg=ReqAddr, remaining=ReqLen, then go to BURST.
  - The rr pointer moves to the other requester after each grant.
- Arbitration: with one request pending, it wins. With both pending, the requester not granted last wins.
- BURST, each cycle is one beat:
  - MemAddress=addr_reg.
  - Write burst: MemWriteEn=1, MemDataIn=owner's WData, owner's BeatAck=1.
  - Read burst: MemWriteEn=0. On the edge, RspData_owner<=MemDataOut and RspValid_owner<=1 (pulse, one cycle later).
  - On each edge, addr_reg<=addr_reg+1, wrapping modulo 256 (255 -> 0). remaining<=remaining-1.
  - If remaining==0 this beat is the last; next state is IDLE.
- In IDLE: MemWriteEn=0, MemAddress holds addr_reg, BeatAck*=0.
- Latency: accept at cycle t, first beat at t+1, last beat at t+1+Len. First read data valid at t+2.
- There is one IDLE cycle between bursts, so the minimum gap is 1 cycle. A new request can be accepted in that IDLE cycle.
- ReqValid and request fields are ignored during BURST. Dropping ReqValid mid-burst does not abort; the burst completes.
- The non-owner's ReqReady, BeatAck and RspValid stay 0 during BURST.
- Reset asserted mid-burst: the burst is aborted immediately and no further writes occur. A partially written region stays as written.
- Len=0: a single beat, then return to IDLE.

Optional Feature:
DATA_MEM_ARB_FIXED_PRIO_EN
- Defined: fixed priority. Requester 0 always wins simultaneous requests, and the rr pointer logic is compiled out.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Package data_mem_arb_pkg holds:
  - ADDR_W, DATA_W, LEN_W constants
  - state_t enum {IDLE, BURST}
  - req_id_t (1-bit owner)
  - req_t struct {write, addr, len}
- Sub-module arb2_pick: combinational two-way winner select plus registered rr pointer. The FIFO-free sequencing stays in the top module.

Test Plan:
- Reset values: hold Reset=0 with both ReqValid=1 -> all outputs 0, no MemWriteEn.
  - Release Reset -> requester 0 granted first.
- Write burst: req0 writes Addr=0x10, Len=3, WData 0xA0..0xA3 -> MemWriteEn high 4 cycles at addresses 0x10..0x13 with those data. BeatAck0 pulses 4 times. Back in IDLE after cycle t+4.
- Read burst: req1 reads Addr=0x10, Len=3 after the above -> RspValid1 high on 4 consecutive cycles starting at t+2, with RspData1 = 0xA0,0xA1,0xA2,0xA3. RspValid0 stays 0.
- Wrap-around: req0 writes Addr=0xFE, Len=3 -> MemAddress sequence 0xFE, 0xFF, 0x00, 0x01.
- Contention: both valid every cycle with Len=0 -> grants alternate 0,1,0,1.
  - With DATA_MEM_ARB_FIXED_PRIO_EN defined -> always 0.
- Reset mid-burst: pull Reset low on the 2nd beat of a Len=7 write -> MemWriteEn drops asynchronously. No writes to addr+2..addr+7. State returns to IDLE.
